color_cmd_sequencer: RTL

Sequences decoded PS/2 key events into committed colour commands for the painting datapath. It sits directly after `KeyboardDecoder`:
- A colour key arms a pending selection.
- Enter commits the selection into a small command FIFO.
- Esc, or an optional timeout, abandons the selection.
- Downstream consumers drain the FIFO over a valid/ready handshake.

---
 rtl/color_cmd_sequencer.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/color_cmd_sequencer.sv
// color_cmd_sequencer
//
// Turns decoded PS/2 key events into committed colour commands. A colour key
// arms a pending selection. Enter commits it into a small show-ahead FIFO.
// Esc, or an optional timeout, abandons it. A downstream consumer drains the
// FIFO over a valid/ready handshake.
//
// Configuration macro: COLOR_SEL_TIMEOUT_EN
//   defined   : a timer limits how long a selection may stay armed (TIMEOUT cycles)
//   undefined : no timer; ARMED is left only by Enter or Esc; TIMEOUT is unused
//
// Parameters:
//   DEPTH   FIFO entries, power of two in 2..16
//   TIMEOUT selection lifetime in clk cycles, >= 2
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   key_valid      one-cycle pulse per decoded key event
//   last_change    {extend, scancode[7:0]} of the event
//   key_is_down    1 = make, 0 = break
//   cmd_valid      FIFO non-empty
//   cmd_ready      consumer accepts the head entry
//   cmd_color      head colour id (4'hC when empty)
//   pending_color  armed colour id (4'hC when none armed)
//   fifo_full      FIFO holds DEPTH entries
//   fifo_count     number of occupied entries
//   drop_cnt       commits lost to a full FIFO, saturating at 255

module color_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 50_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     key_valid,
  input  logic [8:0]               last_change,
  input  logic                     key_is_down,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [3:0]               cmd_color,
  output logic [3:0]               pending_color,
  output logic                     fifo_full,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0] NO_COLOR = 4'hC;

  // Reject illegal parameter combinations at elaboration time.
  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_bad_params
    $error("color_cmd_sequencer: illegal DEPTH or TIMEOUT");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PUSH  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        pending_q, pending_d;
  logic [3:0]        mem_q [DEPTH];
  logic [3:0]        mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [7:0]        drop_q, drop_d;

`ifdef COLOR_SEL_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0]     timer_q, timer_d;
`endif

  logic       ev_used;
  logic       is_color, is_enter, is_esc;
  logic [3:0] color_id;
  logic       color_ev, enter_ev, esc_ev;
  logic       push_req, pop, do_push, drop;

  // Only make events of non-extended codes reach the FSM; everything else is
  // filtered here so the FSM never sees breaks or E0-prefixed keys.
  always_comb begin
    ev_used  = key_valid && key_is_down && !last_change[8];
    is_color = 1'b0;
    is_enter = 1'b0;
    is_esc   = 1'b0;
    color_id = NO_COLOR;
    case (last_change[7:0])
      8'h2D: begin is_color = 1'b1; color_id = 4'h0; end
      8'h2C: begin is_color = 1'b1; color_id = 4'h1; end
      8'h35: begin is_color = 1'b1; color_id = 4'h2; end
      8'h3C: begin is_color = 1'b1; color_id = 4'h3; end
      8'h2B: begin is_color = 1'b1; color_id = 4'h4; end
      8'h34: begin is_color = 1'b1; color_id = 4'h5; end
      8'h33: begin is_color = 1'b1; color_id = 4'h6; end
      8'h3B: begin is_color = 1'b1; color_id = 4'h7; end
      8'h2A: begin is_color = 1'b1; color_id = 4'h8; end
      8'h31: begin is_color = 1'b1; color_id = 4'h9; end
      8'h32: begin is_color = 1'b1; color_id = 4'hA; end
      8'h3A: begin is_color = 1'b1; color_id = 4'hB; end
      8'h5A: is_enter = 1'b1;
      8'h76: is_esc   = 1'b1;
      default: ;
    endcase
    color_ev = ev_used && is_color;
    enter_ev = ev_used && is_enter;
    esc_ev   = ev_used && is_esc;
  end

  // Selection FSM. In ARMED a real key event outranks timer expiry; ignored
  // keys let the timer keep running. PUSH lasts one cycle and ignores keys.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    push_req  = 1'b0;
`ifdef COLOR_SEL_TIMEOUT_EN
    timer_d   = timer_q;
`endif
    case (state_q)
      IDLE: begin
        if (color_ev) begin
          pending_d = color_id;
          state_d   = ARMED;
`ifdef COLOR_SEL_TIMEOUT_EN
          timer_d   = '0;
`endif
        end
      end
      ARMED: begin
        if (color_ev) begin
          pending_d = color_id;
`ifdef COLOR_SEL_TIMEOUT_EN
          timer_d   = '0;
`endif
        end else if (enter_ev) begin
          state_d = PUSH;
        end else if (esc_ev) begin
          pending_d = NO_COLOR;
          state_d   = IDLE;
`ifdef COLOR_SEL_TIMEOUT_EN
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          pending_d = NO_COLOR;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
`endif
        end
      end
      PUSH: begin
        push_req  = 1'b1;
        pending_d = NO_COLOR;
        state_d   = IDLE;
      end
      default: begin
        pending_d = NO_COLOR;
        state_d   = IDLE;
      end
    endcase
  end

  // FIFO bookkeeping. A pop in the PUSH cycle frees the slot being written,
  // so a full FIFO can still accept the commit without losing it.
  always_comb begin
    cmd_valid  = (count_q != '0);
    fifo_full  = (count_q == CW'(DEPTH));
    pop        = cmd_valid && cmd_ready;
    do_push    = push_req && (!fifo_full || pop);
    drop       = push_req && fifo_full && !pop;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_d     = drop_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = pending_q;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (drop && drop_q != 8'hFF) begin
      drop_d = drop_q + 8'd1;
    end
    cmd_color     = cmd_valid ? mem_q[rd_ptr_q] : NO_COLOR;
    pending_color = pending_q;
    fifo_count    = count_q;
    drop_cnt      = drop_q;
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= NO_COLOR;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      drop_q    <= '0;
`ifdef COLOR_SEL_TIMEOUT_EN
      timer_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      drop_q    <= drop_d;
`ifdef COLOR_SEL_TIMEOUT_EN
      timer_q   <= timer_d;
`endif
    end
  end

  // FIFO storage needs no reset: entries are only visible while count > 0.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
